// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding and field widths for the I2C master arbiter
package i2c_arb_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // scan from farthest to nearest so the nearest requester overwrites
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[IW'((int'(ptr) + i) % N)]) begin
        idx = IW'((int'(ptr) + i) % N);
        gnt = '0;
        gnt[idx] = 1'b1;
      end
  end
endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C master among NUM_REQ requesters
// Define I2C_ARB_TIMEOUT_EN to bound WAIT_DONE by TIMEOUT_CYC cycles.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_WAIT    = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_addr2,
  input  logic [DATA_W*NUM_REQ-1:0]   req_dataW,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        m_en,
  output logic                        m_rw,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_addr2,
  output logic [DATA_W-1:0]           m_dataW,
  input  logic                        m_busy,
  input  logic [DATA_W-1:0]           m_dataR
);
  localparam int IW = $clog2(NUM_REQ);
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2((TIMEOUT_CYC > ACK_WAIT ? TIMEOUT_CYC : ACK_WAIT) + 1);
`else
  localparam int CW = $clog2(ACK_WAIT + 1);
  localparam int unused_timeout = TIMEOUT_CYC;
`endif
  state_t state;
  logic [IW-1:0] ptr, idx, gi;
  logic [NUM_REQ-1:0] sel;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N(NUM_REQ)) u_rr (.req(req), .ptr(ptr), .gnt(sel), .idx(idx));
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      m_en    <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_addr2 <= '0;
      m_dataW <= '0;
      ptr     <= '0;
      gi      <= '0;
      cnt     <= '0;
    end else begin
      done <= '0;
      m_en <= 1'b0;
      case (state)
        IDLE: if (|req) state <= ARB;
        ARB:
          if (|req) begin
            gnt     <= sel;
            gi      <= idx;
            m_rw    <= req_rw[idx];
            m_addr  <= req_addr[idx*ADDR_W +: ADDR_W];
            m_addr2 <= req_addr2[idx*DATA_W +: DATA_W];
            m_dataW <= req_dataW[idx*DATA_W +: DATA_W];
            m_en    <= 1'b1;
            state   <= START;
          end else state <= IDLE;
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY:
          if (m_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CW'(ACK_WAIT - 1)) begin
            err   <= 1'b1;
            done  <= gnt;
            state <= COMPLETE;
          end else cnt <= cnt + 1'b1;
        WAIT_DONE:
          if (!m_busy) begin
            err   <= 1'b0;
            done  <= gnt;
            rdata <= m_rw ? m_dataR : rdata;
            state <= COMPLETE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            err   <= 1'b1;
            done  <= gnt;
            state <= COMPLETE;
          end else cnt <= cnt + 1'b1;
`endif
        COMPLETE: begin
          gnt   <= '0;
          ptr   <= (gi == IW'(NUM_REQ - 1)) ? '0 : gi + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed and randomized checks against a round-robin reference model
module tb_i2c_arbiter;
  localparam int N = 4, AW = 16, TO = 100;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0, req_rw = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_addr2 = '0, req_dataW = '0;
  logic [N-1:0] gnt, done, od;
  logic err, m_en, m_rw;
  logic [7:0] rdata, m_addr2, m_dataW;
  logic [6:0] m_addr;
  logic m_busy = 1'b0;
  logic [7:0] m_dataR = '0;
  int n_cmp = 0, n_bad = 0;
  int ptr = 0, t_en = 0, t_done = 0;
  logic [7:0] exp_rdata = '0;

  always #5 clock = ~clock;

  i2c_arbiter #(.NUM_REQ(N), .ACK_WAIT(AW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_addr2(req_addr2), .req_dataW(req_dataW), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_addr2(m_addr2),
    .m_dataW(m_dataW), .m_busy(m_busy), .m_dataR(m_dataR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: nearest requester at or after the pointer, wrapping
  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  function automatic bit busy_at(input int k, input int lat, input int len);
    return lat >= 0 && k >= lat && (len < 0 || k < lat + len);
  endfunction

  task automatic txn(input int lat, input int len, input logic [7:0] dr, input bit mutate,
                     input bit expect_done, input int lim, output logic [N-1:0] obs_done);
    int g, k;
    logic [23:0] fld;
    bit eerr;
    g = pick();
    fld = {req_rw[g], req_addr[g*7 +: 7], req_addr2[g*8 +: 8], req_dataW[g*8 +: 8]};
    eerr = lat < 0 || len < 0;
    t_en = 0;
    do begin
      @(negedge clock);
      t_en++;
    end while (!m_en && t_en < 20);
    chk("m_en_seen", 32'(m_en), 1);
    chk("gnt", 32'(gnt), 32'(1 << g));
    chk("m_fields", 32'({m_rw, m_addr, m_addr2, m_dataW}), 32'(fld));
    m_dataR = dr;
    m_busy = busy_at(0, lat, len);
    for (k = 1; k <= lim; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("m_en_pulse", 32'(m_en), 0);
        if (mutate) begin
          req_rw = 4'($urandom);
          req_addr = 28'($urandom);
          req_addr2 = $urandom;
          req_dataW = $urandom;
          if ($urandom_range(0, 1) == 1) req[g] = 1'b0;
        end
      end
      if (done != '0) break;
      m_busy = busy_at(k, lat, len);
    end
    t_done = k;
    obs_done = done;
    if (!expect_done) chk("no_done", 32'(t_done > lim), 1);
    else begin
      m_busy = 1'b0;
      chk("done_seen", 32'(t_done <= lim), 1);
      chk("done", 32'(done), 32'(1 << g));
      chk("err", 32'(err), 32'(eerr));
      if (!eerr && fld[23]) exp_rdata = dr;
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("m_hold", 32'({m_rw, m_addr, m_addr2, m_dataW}), 32'(fld));
      ptr = (g + 1) % N;
      @(negedge clock);
      chk("done_pulse", 32'(done), 0);
      chk("gnt_clr", 32'(gnt), 0);
    end
  endtask

  initial begin
    int lat, len;
    repeat (3) @(negedge clock);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_m", 32'({m_en, m_rw, m_addr, m_addr2, m_dataW}), 0);
    reset = 1'b0;
    @(negedge clock);
    req_addr[6:0] = 7'h50;
    req_addr2[7:0] = 8'h10;
    req_dataW[7:0] = 8'hA5;
    req = 4'b0001;
    txn(1, 40, 8'h00, 1'b0, 1'b1, 200, od);
    chk("wr_latency", 32'(t_en), 2);
    chk("wr_done", 32'(od), 32'b0001);
    chk("wr_err", 32'(err), 0);
    req = '0;
    req_rw[2] = 1'b1;
    req_addr[20:14] = 7'h21;
    req = 4'b0100;
    txn(3, 6, 8'h3C, 1'b0, 1'b1, 200, od);
    chk("rd_done", 32'(od), 32'b0100);
    chk("rd_data", 32'(rdata), 32'h3C);
    req = 4'b0010;
    txn(-1, 0, 8'h77, 1'b0, 1'b1, 200, od);
    chk("ack_time", 32'(t_done), AW + 1);
    chk("ack_done", 32'(od), 32'b0010);
    req = 4'b1000;
    txn(0, 2, 8'h00, 1'b0, 1'b1, 200, od);
    chk("min_lat", 32'(t_en + t_done), 5);
    chk("after_ack", 32'(od), 32'b1000);
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      txn(0, 3, 8'h00, 1'b0, 1'b1, 200, od);
      chk("rr_order", 32'(od), 32'(1 << (i % 4)));
    end
    for (int r = 0; r < 24; r++) begin
      req_rw = 4'($urandom);
      req_addr = 28'($urandom);
      req_addr2 = $urandom;
      req_dataW = $urandom;
      req = 4'($urandom_range(1, 15));
      lat = int'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) lat = -1;
      len = int'($urandom_range(2, 20));
      txn(lat, len, 8'($urandom), 1'b1, 1'b1, 200, od);
    end
`ifdef I2C_ARB_TIMEOUT_EN
    req = 4'b0001;
    txn(0, -1, 8'h00, 1'b0, 1'b1, 200, od);
    chk("to_time", 32'(t_done), TO + 2);
`endif
    req = 4'b0010;
    txn(0, 2, 8'h00, 1'b0, 1'b1, 200, od);
    req = 4'b0100;
    txn(0, -1, 8'h00, 1'b0, 1'b0, 90, od);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_m", 32'({m_en, m_rw, m_addr, m_addr2, m_dataW}), 0);
    ptr = 0;
    exp_rdata = '0;
    reset = 1'b0;
    m_busy = 1'b0;
    req = 4'hF;
    txn(0, 2, 8'h00, 1'b0, 1'b1, 200, od);
    chk("ptr_reset", 32'(od), 32'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
